// File: rtl/lsu_trigger_pipe_pkg.sv
// Shared types and constants for the LSU trigger dc4/dc5 pipe.
// The stage struct is sized from the package trigger count.
package lsu_trigger_pipe_pkg;

   localparam int unsigned LSU_NUM_TRIG = 4;
   localparam int unsigned LSU_CNT_W    = 8;

   localparam logic TRIG_ACT_EXC  = 1'b0;
   localparam logic TRIG_ACT_HALT = 1'b1;

   typedef struct packed {
      logic                    valid;
      logic [LSU_NUM_TRIG-1:0] match;
   } trig_stage_t;

endpackage

// File: rtl/lsu_trig_cnt.sv
// Per-trigger sticky hit bit and saturating hit counter.
// A clear in the same cycle as a hit leaves status set and the count at one.
module lsu_trig_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_hit,
   input  logic             i_clr,
   output logic             o_status,
   output logic [CNT_W-1:0] o_cnt
);

   logic             r_status;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_base;

   always_comb begin
      w_base = i_clr ? '0 : r_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_status <= (r_status & ~i_clr) | i_hit;
         if (i_hit && (w_base != {CNT_W{1'b1}})) begin
            r_cnt <= w_base + CNT_W'(1);
         end else begin
            r_cnt <= w_base;
         end
      end
   end

   assign o_status = r_status;
   assign o_cnt    = r_cnt;

endmodule

// File: rtl/lsu_trigger_pipe.sv
// Stages dc3 trigger matches through dc4/dc5, applies chain pairing and
// produces the dc5 hit vector, halt/exception action and debug status.
module lsu_trigger_pipe
   import lsu_trigger_pipe_pkg::*;
#(
   parameter int unsigned NUM_TRIG = LSU_NUM_TRIG,
   parameter int unsigned CNT_W    = LSU_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_TRIG-1:0]       lsu_trigger_match_dc3,
   input  logic                      lsu_pkt_valid_dc3,
   input  logic                      lsu_freeze_dc3,
   input  logic                      dec_tlu_flush_lower_dc5,
   input  logic [NUM_TRIG-1:0]       trig_chain,
   input  logic [NUM_TRIG-1:0]       trig_action,
   input  logic [NUM_TRIG-1:0]       status_clr,
   output logic [NUM_TRIG-1:0]       lsu_trigger_hit_dc5,
   output logic                      lsu_trigger_halt_dc5,
   output logic                      lsu_trigger_exc_dc5,
   output logic [NUM_TRIG-1:0]       trig_status,
   output logic [NUM_TRIG*CNT_W-1:0] trig_hit_cnt
);

   trig_stage_t         r_dc4;
   logic                r_v5;
   logic [NUM_TRIG-1:0] r_h5;
   logic [NUM_TRIG-1:0] w_q;
   logic [NUM_TRIG-1:0] w_halt_vec;
   logic [NUM_TRIG-1:0] w_exc_vec;
   logic [NUM_TRIG-1:0] w_upd;
   logic                w_unused_chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dc4 <= '0;
         r_v5  <= 1'b0;
         r_h5  <= '0;
      end else if (!lsu_freeze_dc3) begin
         r_dc4.valid <= lsu_pkt_valid_dc3;
         r_dc4.match <= lsu_trigger_match_dc3 & {NUM_TRIG{lsu_pkt_valid_dc3}};
         r_v5        <= r_dc4.valid & ~dec_tlu_flush_lower_dc5;
         r_h5        <= w_q & {NUM_TRIG{r_dc4.valid & ~dec_tlu_flush_lower_dc5}};
      end else if (dec_tlu_flush_lower_dc5) begin
         // A held dc4 entry is still killed by flush.
         r_dc4 <= '0;
      end
   end

   always_comb begin
      w_q = r_dc4.match;
      for (int i = 0; i < NUM_TRIG; i += 2) begin
         if (trig_chain[i]) begin
            w_q[i]   = r_dc4.match[i] & r_dc4.match[i+1];
            w_q[i+1] = r_dc4.match[i] & r_dc4.match[i+1];
         end
      end
   end

   always_comb begin
      w_unused_chain = 1'b0;
      for (int i = 1; i < NUM_TRIG; i += 2) begin
         w_unused_chain = w_unused_chain ^ trig_chain[i];
      end
   end

   always_comb begin
      w_halt_vec = '0;
      w_exc_vec  = '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
         w_halt_vec[i] = r_h5[i] & (trig_action[i] == TRIG_ACT_HALT);
         w_exc_vec[i]  = r_h5[i] & (trig_action[i] == TRIG_ACT_EXC);
      end
   end

   assign lsu_trigger_hit_dc5  = r_h5;
   assign lsu_trigger_halt_dc5 = |w_halt_vec;
   assign lsu_trigger_exc_dc5  = (|w_exc_vec) & ~(|w_halt_vec);

   // Only unfrozen dc5 cycles count, so a held entry is counted once.
   assign w_upd = r_h5 & {NUM_TRIG{r_v5 & ~lsu_freeze_dc3}};

   for (genvar g = 0; g < NUM_TRIG; g++) begin : g_cnt
      lsu_trig_cnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .i_hit    (w_upd[g]),
         .i_clr    (status_clr[g]),
         .o_status (trig_status[g]),
         .o_cnt    (trig_hit_cnt[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_lsu_trigger_pipe.sv
// Scoreboard bench for lsu_trigger_pipe: expected dc5 hits queued at dc3 drive time.
module tb_lsu_trigger_pipe;

   localparam int unsigned NT = 4;
   localparam int unsigned CW = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NT-1:0]  match_dc3;
   logic           valid_dc3;
   logic           freeze;
   logic           flush;
   logic [NT-1:0]  chain;
   logic [NT-1:0]  action;
   logic [NT-1:0]  clr;
   logic [NT-1:0]  hit_dc5;
   logic           halt_dc5;
   logic           exc_dc5;
   logic [NT-1:0]  status;
   logic [NT*CW-1:0] hit_cnt;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   logic [NT-1:0] sb_q[$];
   logic [NT-1:0] exp_h5;
   logic [NT-1:0] exp_status;
   logic [CW-1:0] exp_cnt [NT];

   always #5 clk = ~clk;

   lsu_trigger_pipe #(
      .NUM_TRIG (NT),
      .CNT_W    (CW)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .lsu_trigger_match_dc3   (match_dc3),
      .lsu_pkt_valid_dc3       (valid_dc3),
      .lsu_freeze_dc3          (freeze),
      .dec_tlu_flush_lower_dc5 (flush),
      .trig_chain              (chain),
      .trig_action             (action),
      .status_clr              (clr),
      .lsu_trigger_hit_dc5     (hit_dc5),
      .lsu_trigger_halt_dc5    (halt_dc5),
      .lsu_trigger_exc_dc5     (exc_dc5),
      .trig_status             (status),
      .trig_hit_cnt            (hit_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h exp=%0h", tag, step_no, got, exp);
      end
   endtask

   function automatic logic [NT-1:0] qualify(input logic [NT-1:0] m, input logic [NT-1:0] ch);
      logic [NT-1:0] r;
      r = m;
      for (int i = 0; i < NT; i += 2) begin
         if (ch[i]) begin
            r[i]   = m[i] & m[i+1];
            r[i+1] = m[i] & m[i+1];
         end
      end
      return r;
   endfunction

   function automatic logic [NT*CW-1:0] pack_cnt();
      logic [NT*CW-1:0] v;
      for (int i = 0; i < NT; i++) v[i*CW +: CW] = exp_cnt[i];
      return v;
   endfunction

   task automatic compare_outputs();
      logic exp_halt;
      logic exp_exc;
      exp_halt = |(exp_h5 & action);
      exp_exc  = (|(exp_h5 & ~action)) & ~exp_halt;
      check_val("hit_dc5", 32'(hit_dc5), 32'(exp_h5));
      check_val("halt_dc5", 32'(halt_dc5), 32'(exp_halt));
      check_val("exc_dc5", 32'(exc_dc5), 32'(exp_exc));
      check_val("status", 32'(status), 32'(exp_status));
      check_val("hit_cnt", hit_cnt, pack_cnt());
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst       = 1'b1;
      match_dc3 = '1;
      valid_dc3 = 1'b1;
      freeze    = 1'b0;
      flush     = 1'b0;
      clr       = '0;
      repeat (cycles) @(posedge clk);
      #1;
      sb_q.delete();
      sb_q.push_back('0);
      exp_h5     = '0;
      exp_status = '0;
      for (int i = 0; i < NT; i++) exp_cnt[i] = '0;
      compare_outputs();
      rst       = 1'b0;
      match_dc3 = '0;
      valid_dc3 = 1'b0;
   endtask

   task automatic step(input logic [NT-1:0] m, input logic v, input logic frz,
                       input logic fl, input logic [NT-1:0] c);
      logic [NT-1:0] nxt_status;
      logic [CW-1:0] nxt_cnt [NT];
      @(negedge clk);
      step_no++;
      match_dc3 = m;
      valid_dc3 = v;
      freeze    = frz;
      flush     = fl;
      clr       = c;
      for (int i = 0; i < NT; i++) begin
         nxt_status[i] = (exp_status[i] & ~c[i]) | (~frz & exp_h5[i]);
         nxt_cnt[i]    = c[i] ? '0 : exp_cnt[i];
         if (!frz && exp_h5[i] && nxt_cnt[i] != {CW{1'b1}}) nxt_cnt[i] = nxt_cnt[i] + 1'b1;
      end
      if (fl) sb_q[$] = '0;
      if (!frz) sb_q.push_back(qualify(m & {NT{v}}, chain));
      @(posedge clk);
      #1;
      if (!frz) exp_h5 = sb_q.pop_front();
      exp_status = nxt_status;
      for (int i = 0; i < NT; i++) exp_cnt[i] = nxt_cnt[i];
      compare_outputs();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      chain  = '0;
      action = '0;
      do_reset(2);

      // Latency and basic exception action.
      step(4'b0001, 1'b1, 1'b0, 1'b0, '0);
      idle(3);
      step(4'b1111, 1'b0, 1'b0, 1'b0, '0);
      idle(2);

      // Chain pairing on both pairs; odd chain bits set to show they are ignored.
      chain = 4'b1111;
      step(4'b0001, 1'b1, 1'b0, 1'b0, '0);
      step(4'b0011, 1'b1, 1'b0, 1'b0, '0);
      step(4'b0100, 1'b1, 1'b0, 1'b0, '0);
      step(4'b1100, 1'b1, 1'b0, 1'b0, '0);
      idle(2);
      chain = '0;

      // Halt priority, then the same entry killed by flush in dc4.
      action = 4'b0100;
      step(4'b0101, 1'b1, 1'b0, 1'b0, '0);
      idle(2);
      step(4'b0101, 1'b1, 1'b0, 1'b0, '0);
      step('0, 1'b0, 1'b0, 1'b1, '0);
      idle(2);
      action = '0;

      // Freeze with an entry held in dc5 for three extra cycles.
      step(4'b0010, 1'b1, 1'b0, 1'b0, '0);
      step(4'b1000, 1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 3; k++) step(4'b0001, 1'b1, 1'b1, 1'b0, '0);
      idle(3);
      // Flush during freeze empties the held dc4 entry.
      step(4'b0100, 1'b1, 1'b0, 1'b0, '0);
      step('0, 1'b0, 1'b1, 1'b1, '0);
      idle(3);

      // Reset in the middle of traffic.
      step(4'b1111, 1'b1, 1'b0, 1'b0, '0);
      step(4'b1111, 1'b1, 1'b0, 1'b0, '0);
      do_reset(1);
      idle(2);

      // Saturation on trigger 3.
      for (int k = 0; k < 260; k++) step(4'b1000, 1'b1, 1'b0, 1'b0, '0);
      idle(2);
      check_val("sat_cnt3", 32'(hit_cnt[3*CW +: CW]), 32'd255);

      // Clear together with a hit, then clear alone.
      step(4'b1000, 1'b1, 1'b0, 1'b0, '0);
      step('0, 1'b0, 1'b0, 1'b0, '0);
      step('0, 1'b0, 1'b0, 1'b0, 4'b1000);
      check_val("clr_hit_st3", 32'(status[3]), 32'd1);
      check_val("clr_hit_cnt3", 32'(hit_cnt[3*CW +: CW]), 32'd1);
      step('0, 1'b0, 1'b0, 1'b0, 4'b1001);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
